// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the one-hot load and store size encodings (also used by the
// write-back control), the LSU FSM state enum, bus widths and the default
// response timeout.
package lsu_pkg;

  localparam int LSU_AW = 64;
  localparam int LSU_DW = 64;
  localparam int LSU_SW = LSU_DW / 8;

  // WAIT cycles without a response before the access is abandoned.
  localparam int LSU_TIMEOUT_DEFAULT = 255;

  typedef logic [6:0] ld_op_t;
  typedef logic [3:0] st_op_t;

  localparam ld_op_t LD_OP_LD  = 7'b0000001;
  localparam ld_op_t LD_OP_LW  = 7'b0000010;
  localparam ld_op_t LD_OP_LH  = 7'b0000100;
  localparam ld_op_t LD_OP_LB  = 7'b0001000;
  localparam ld_op_t LD_OP_LWU = 7'b0010000;
  localparam ld_op_t LD_OP_LHU = 7'b0100000;
  localparam ld_op_t LD_OP_LBU = 7'b1000000;

  localparam st_op_t ST_OP_SD = 4'b0001;
  localparam st_op_t ST_OP_SW = 4'b0010;
  localparam st_op_t ST_OP_SH = 4'b0100;
  localparam st_op_t ST_OP_SB = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Memory bus between the LSU and the data memory / interconnect.
//   req_valid/req_ready : request handshake (LSU -> memory)
//   req_addr            : doubleword-aligned address
//   req_we              : 1 for a store
//   req_wdata/req_wstrb : store data in its byte lanes and lane strobes
//   resp_valid          : read or write response
//   resp_rdata          : aligned doubleword read data
interface lsu_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [LSU_AW-1:0] req_addr;
  logic              req_we;
  logic [LSU_DW-1:0] req_wdata;
  logic [LSU_SW-1:0] req_wstrb;
  logic              resp_valid;
  logic [LSU_DW-1:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational alignment helper for the LSU.
// Given the access size, the byte offset within the doubleword and the
// store data, produces the misalignment flag, the byte-lane strobes and
// the store data shifted into its lanes.
//   is_load  : 1 selects rd_op, 0 selects wr_op
//   rd_op    : one-hot load size
//   wr_op    : one-hot store size
//   off      : address bits [2:0]
//   wr_data  : right-aligned store data
//   misalign : access violates its natural alignment
//   wstrb    : byte-lane strobes (0 for loads)
//   wdata    : store data shifted by off bytes (0 for loads)
module lsu_align
  import lsu_pkg::*;
(
  input  logic              is_load,
  input  ld_op_t            rd_op,
  input  st_op_t            wr_op,
  input  logic [2:0]        off,
  input  logic [LSU_DW-1:0] wr_data,
  output logic              misalign,
  output logic [LSU_SW-1:0] wstrb,
  output logic [LSU_DW-1:0] wdata
);

  always_comb begin
    misalign = 1'b0;
    wstrb    = '0;
    wdata    = '0;
    if (is_load) begin
      case (rd_op)
        LD_OP_LD:             misalign = (off != 3'd0);
        LD_OP_LW, LD_OP_LWU:  misalign = (off[1:0] != 2'd0);
        LD_OP_LH, LD_OP_LHU:  misalign = off[0];
        LD_OP_LB, LD_OP_LBU:  misalign = 1'b0;
        default:              misalign = 1'b0;
      endcase
    end else begin
      wdata = wr_data << {off, 3'b000};
      case (wr_op)
        ST_OP_SD: begin
          misalign = (off != 3'd0);
          wstrb    = 8'hFF;
        end
        ST_OP_SW: begin
          misalign = (off[1:0] != 2'd0);
          wstrb    = 8'h0F << off;
        end
        ST_OP_SH: begin
          misalign = off[0];
          wstrb    = 8'h03 << off;
        end
        ST_OP_SB: begin
          misalign = 1'b0;
          wstrb    = 8'h01 << off;
        end
        default: begin
          misalign = 1'b0;
          wstrb    = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns decode-stage load/store requests into single
// doubleword bus transactions, stalls the pipeline while an access is
// outstanding and returns load data shifted down to bit 0.
//   clk, rst     : clock, synchronous active-high reset
//   mem_rd_en    : load request (wins if mem_wr_en is also high)
//   mem_wr_en    : store request
//   rd_mem_op    : one-hot load size
//   wr_mem_op    : one-hot store size
//   rd_mem_addr  : byte address
//   wr_mem_data  : right-aligned store data
//   mem_rd_data  : load data, addressed byte at bit 0 (held until next capture)
//   stall        : pipeline freeze while an access is in flight
//   done         : one-cycle completion pulse
//   misalign     : one-cycle pulse when a start is rejected as misaligned
//   bus_err      : one-cycle pulse when the response times out
//   bus          : memory bus (master side)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no access; accepts a start, rejects misaligned ones at once
// REQ   | req_valid high, request fields frozen until req_ready
// WAIT  | request accepted, waiting for resp_valid or the timeout
// DONE  | done pulse, mem_rd_data valid, pipeline released
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  ld_op_t            rd_mem_op,
  input  st_op_t            wr_mem_op,
  input  logic [LSU_AW-1:0] rd_mem_addr,
  input  logic [LSU_DW-1:0] wr_mem_data,
  output logic [LSU_DW-1:0] mem_rd_data,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  output logic              bus_err,
  lsu_if.master             bus
);

  // Down-counter is loaded with TIMEOUT-1 on entry to WAIT, so it always
  // fits in clog2(TIMEOUT) bits.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e        state;
  logic [CW-1:0]     wait_cnt;
  logic [2:0]        off_q;
  logic              req_valid_q;
  logic              req_we_q;
  logic [LSU_AW-1:0] req_addr_q;
  logic [LSU_DW-1:0] req_wdata_q;
  logic [LSU_SW-1:0] req_wstrb_q;

  logic              start;
  logic              a_misalign;
  logic [LSU_SW-1:0] a_wstrb;
  logic [LSU_DW-1:0] a_wdata;

  assign start = mem_rd_en | mem_wr_en;

  lsu_align u_align (
    .is_load  (mem_rd_en),
    .rd_op    (rd_mem_op),
    .wr_op    (wr_mem_op),
    .off      (rd_mem_addr[2:0]),
    .wr_data  (wr_mem_data),
    .misalign (a_misalign),
    .wstrb    (a_wstrb),
    .wdata    (a_wdata)
  );

  // Cycle-0 terms must be combinational: the pipeline has to freeze (or
  // learn of the rejection) in the same cycle the request is presented.
  assign misalign = (state == IDLE) & start & a_misalign;
  assign stall    = ((state == IDLE) & start & ~a_misalign)
                  | (state == REQ) | (state == WAIT);

  assign bus.req_valid = req_valid_q;
  assign bus.req_we    = req_we_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_wdata = req_wdata_q;
  assign bus.req_wstrb = req_wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      off_q       <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      mem_rd_data <= '0;
      done        <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !a_misalign) begin
            req_addr_q  <= {rd_mem_addr[LSU_AW-1:3], 3'b000};
            off_q       <= rd_mem_addr[2:0];
            req_we_q    <= ~mem_rd_en;
            req_wstrb_q <= a_wstrb;
            req_wdata_q <= a_wdata;
            req_valid_q <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (bus.req_ready) begin
            req_valid_q <= 1'b0;
            wait_cnt    <= CW'(TIMEOUT - 1);
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (bus.resp_valid) begin
            mem_rd_data <= bus.resp_rdata >> {off_q, 3'b000};
            done        <= 1'b1;
            wait_cnt    <= '0;
            state       <= DONE;
          end else if (wait_cnt == '0) begin
            mem_rd_data <= '0;
            done        <= 1'b1;
            bus_err     <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu. Inputs change 1 ns after each rising edge and
// outputs are sampled on the falling edge. The DUT runs with TIMEOUT=4.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [6:0]  rd_mem_op;
  logic [3:0]  wr_mem_op;
  logic [63:0] rd_mem_addr;
  logic [63:0] wr_mem_data;
  logic [63:0] mem_rd_data;
  logic        stall;
  logic        done;
  logic        misalign;
  logic        bus_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_if bus ();

  lsu #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .rd_mem_op   (rd_mem_op),
    .wr_mem_op   (wr_mem_op),
    .rd_mem_addr (rd_mem_addr),
    .wr_mem_data (wr_mem_data),
    .mem_rd_data (mem_rd_data),
    .stall       (stall),
    .done        (done),
    .misalign    (misalign),
    .bus_err     (bus_err),
    .bus         (bus)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    rd_mem_op = '0;
    wr_mem_op = '0;
    rd_mem_addr = '0;
    wr_mem_data = '0;
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_inputs();
    next_cycle();
    next_cycle();
    sample();
    n_vec++; if (bus.req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got %b exp 0", bus.req_valid); end
    n_vec++; if (bus.req_we !== 1'b0) begin n_err++; $display("FAIL rst_req_we got %b exp 0", bus.req_we); end
    n_vec++; if (bus.req_addr !== 64'h0) begin n_err++; $display("FAIL rst_req_addr got %h exp 0", bus.req_addr); end
    n_vec++; if (bus.req_wdata !== 64'h0) begin n_err++; $display("FAIL rst_req_wdata got %h exp 0", bus.req_wdata); end
    n_vec++; if (bus.req_wstrb !== 8'h0) begin n_err++; $display("FAIL rst_req_wstrb got %h exp 0", bus.req_wstrb); end
    n_vec++; if (mem_rd_data !== 64'h0) begin n_err++; $display("FAIL rst_rd_data got %h exp 0", mem_rd_data); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", done); end
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign got %b exp 0", misalign); end
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rst_bus_err got %b exp 0", bus_err); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", stall); end
    next_cycle();
    rst = 1'b0;
    sample();
    n_vec++; if (bus.req_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_req_valid got %b exp 0", bus.req_valid); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL post_rst_stall got %b exp 0", stall); end
    next_cycle();
  endtask

  // LW at 0x1004, ready at once, response one cycle later.
  task automatic test_load_lw();
    mem_rd_en = 1'b1; rd_mem_op = LD_OP_LW; rd_mem_addr = 64'h1004; bus.req_ready = 1'b1;
    sample();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lw_c0_stall got %b exp 1", stall); end
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL lw_c0_misalign got %b exp 0", misalign); end
    n_vec++; if (bus.req_valid !== 1'b0) begin n_err++; $display("FAIL lw_c0_req_valid got %b exp 0", bus.req_valid); end
    next_cycle();
    mem_rd_en = 1'b0;
    sample();
    n_vec++; if (bus.req_valid !== 1'b1) begin n_err++; $display("FAIL lw_c1_req_valid got %b exp 1", bus.req_valid); end
    n_vec++; if (bus.req_addr !== 64'h1000) begin n_err++; $display("FAIL lw_req_addr got %h exp 1000", bus.req_addr); end
    n_vec++; if (bus.req_we !== 1'b0) begin n_err++; $display("FAIL lw_req_we got %b exp 0", bus.req_we); end
    n_vec++; if (bus.req_wstrb !== 8'h00) begin n_err++; $display("FAIL lw_req_wstrb got %h exp 00", bus.req_wstrb); end
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lw_c1_stall got %b exp 1", stall); end
    next_cycle();
    bus.req_ready = 1'b0; bus.resp_valid = 1'b1; bus.resp_rdata = 64'hDEADBEEF_12345678;
    sample();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lw_c2_stall got %b exp 1", stall); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL lw_c2_done got %b exp 0", done); end
    n_vec++; if (bus.req_valid !== 1'b0) begin n_err++; $display("FAIL lw_c2_req_valid got %b exp 0", bus.req_valid); end
    next_cycle();
    bus.resp_valid = 1'b0;
    sample();
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL lw_c3_done got %b exp 1", done); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lw_c3_stall got %b exp 0", stall); end
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL lw_c3_bus_err got %b exp 0", bus_err); end
    n_vec++; if (mem_rd_data !== 64'h00000000_DEADBEEF) begin n_err++; $display("FAIL lw_rd_data got %h exp 00000000deadbeef", mem_rd_data); end
    next_cycle();
    sample();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL lw_c4_done got %b exp 0", done); end
    n_vec++; if (mem_rd_data !== 64'h00000000_DEADBEEF) begin n_err++; $display("FAIL lw_rd_data_hold got %h exp 00000000deadbeef", mem_rd_data); end
    clr_inputs();
    next_cycle();
  endtask

  // SB at 0x2003 with data 0xAB.
  task automatic test_store_sb();
    mem_wr_en = 1'b1; wr_mem_op = ST_OP_SB; rd_mem_addr = 64'h2003; wr_mem_data = 64'hAB;
    sample();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL sb_c0_stall got %b exp 1", stall); end
    n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL sb_c0_misalign got %b exp 0", misalign); end
    next_cycle();
    mem_wr_en = 1'b0; bus.req_ready = 1'b1;
    sample();
    n_vec++; if (bus.req_valid !== 1'b1) begin n_err++; $display("FAIL sb_req_valid got %b exp 1", bus.req_valid); end
    n_vec++; if (bus.req_addr !== 64'h2000) begin n_err++; $display("FAIL sb_req_addr got %h exp 2000", bus.req_addr); end
    n_vec++; if (bus.req_wstrb !== 8'h08) begin n_err++; $display("FAIL sb_req_wstrb got %h exp 08", bus.req_wstrb); end
    n_vec++; if (bus.req_wdata !== 64'h00000000_AB000000) begin n_err++; $display("FAIL sb_req_wdata got %h exp 00000000ab000000", bus.req_wdata); end
    n_vec++; if (bus.req_we !== 1'b1) begin n_err++; $display("FAIL sb_req_we got %b exp 1", bus.req_we); end
    next_cycle();
    bus.req_ready = 1'b0; bus.resp_valid = 1'b1; bus.resp_rdata = 64'h0;
    sample();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL sb_wait_stall got %b exp 1", stall); end
    next_cycle();
    bus.resp_valid = 1'b0;
    sample();
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL sb_done got %b exp 1", done); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL sb_done_stall got %b exp 0", stall); end
    clr_inputs();
    next_cycle();
  endtask

  // LH@0x3001, SW@0x4002, LD@0x4004: all rejected in cycle 0.
  task automatic test_misalign();
    logic        ld [3] = '{1'b1, 1'b0, 1'b1};
    logic [6:0]  rop[3] = '{LD_OP_LH, 7'd0, LD_OP_LD};
    logic [3:0]  wop[3] = '{4'd0, ST_OP_SW, 4'd0};
    logic [63:0] adr[3] = '{64'h3001, 64'h4002, 64'h4004};
    for (int i = 0; i < 3; i++) begin
      mem_rd_en = ld[i]; mem_wr_en = ~ld[i]; rd_mem_op = rop[i]; wr_mem_op = wop[i];
      rd_mem_addr = adr[i]; wr_mem_data = 64'h55; bus.req_ready = 1'b1;
      sample();
      n_vec++; if (misalign !== 1'b1) begin n_err++; $display("FAIL mis%0d_pulse got %b exp 1", i, misalign); end
      n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mis%0d_stall got %b exp 0", i, stall); end
      next_cycle();
      clr_inputs();
      sample();
      n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL mis%0d_after got %b exp 0", i, misalign); end
      n_vec++; if (bus.req_valid !== 1'b0) begin n_err++; $display("FAIL mis%0d_req_valid got %b exp 0", i, bus.req_valid); end
      next_cycle();
      sample();
      n_vec++; if (bus.req_valid !== 1'b0) begin n_err++; $display("FAIL mis%0d_req_valid2 got %b exp 0", i, bus.req_valid); end
      next_cycle();
    end
  endtask

  // SH at 0x5006, req_ready held low for 5 REQ cycles.
  task automatic test_stall_ready();
    int hs = 0;
    mem_wr_en = 1'b1; wr_mem_op = ST_OP_SH; rd_mem_addr = 64'h5006; wr_mem_data = 64'h1234;
    sample();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL sh_c0_stall got %b exp 1", stall); end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      mem_wr_en = 1'b0;
      sample();
      if (bus.req_valid && bus.req_ready) hs++;
      n_vec++; if (bus.req_valid !== 1'b1) begin n_err++; $display("FAIL sh_hold%0d_valid got %b exp 1", i, bus.req_valid); end
      n_vec++; if (bus.req_addr !== 64'h5000) begin n_err++; $display("FAIL sh_hold%0d_addr got %h exp 5000", i, bus.req_addr); end
      n_vec++; if (bus.req_wstrb !== 8'hC0) begin n_err++; $display("FAIL sh_hold%0d_wstrb got %h exp c0", i, bus.req_wstrb); end
      n_vec++; if (bus.req_wdata !== 64'h1234_0000_0000_0000) begin n_err++; $display("FAIL sh_hold%0d_wdata got %h exp 1234000000000000", i, bus.req_wdata); end
      n_vec++; if (bus.req_we !== 1'b1) begin n_err++; $display("FAIL sh_hold%0d_we got %b exp 1", i, bus.req_we); end
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL sh_hold%0d_stall got %b exp 1", i, stall); end
    end
    next_cycle();
    bus.req_ready = 1'b1;
    sample();
    if (bus.req_valid && bus.req_ready) hs++;
    n_vec++; if (bus.req_valid !== 1'b1) begin n_err++; $display("FAIL sh_hs_valid got %b exp 1", bus.req_valid); end
    next_cycle();
    sample();
    if (bus.req_valid && bus.req_ready) hs++;
    n_vec++; if (bus.req_valid !== 1'b0) begin n_err++; $display("FAIL sh_post_hs_valid got %b exp 0", bus.req_valid); end
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL sh_wait_stall got %b exp 1", stall); end
    next_cycle();
    bus.req_ready = 1'b0; bus.resp_valid = 1'b1; bus.resp_rdata = 64'hFFEEDDCC_BBAA9988;
    sample();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL sh_wait2_stall got %b exp 1", stall); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL sh_wait2_done got %b exp 0", done); end
    next_cycle();
    bus.resp_valid = 1'b0;
    sample();
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL sh_done got %b exp 1", done); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL sh_done_stall got %b exp 0", stall); end
    n_vec++; if (mem_rd_data !== 64'h0000_0000_0000_FFEE) begin n_err++; $display("FAIL sh_rd_data got %h exp 000000000000ffee", mem_rd_data); end
    n_vec++; if (hs !== 1) begin n_err++; $display("FAIL sh_handshakes got %0d exp 1", hs); end
    clr_inputs();
    next_cycle();
  endtask

  // Load and store together: load wins; a response during REQ is ignored.
  task automatic test_dual_start();
    mem_rd_en = 1'b1; mem_wr_en = 1'b1; rd_mem_op = LD_OP_LD; wr_mem_op = ST_OP_SD;
    rd_mem_addr = 64'h8008; wr_mem_data = 64'hCAFE;
    sample();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL dual_c0_stall got %b exp 1", stall); end
    next_cycle();
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; bus.resp_valid = 1'b1; bus.resp_rdata = 64'h1111;
    sample();
    n_vec++; if (bus.req_we !== 1'b0) begin n_err++; $display("FAIL dual_req_we got %b exp 0", bus.req_we); end
    n_vec++; if (bus.req_wstrb !== 8'h00) begin n_err++; $display("FAIL dual_req_wstrb got %h exp 00", bus.req_wstrb); end
    n_vec++; if (bus.req_addr !== 64'h8008) begin n_err++; $display("FAIL dual_req_addr got %h exp 8008", bus.req_addr); end
    next_cycle();
    bus.resp_valid = 1'b0; bus.req_ready = 1'b1;
    sample();
    n_vec++; if (bus.req_valid !== 1'b1) begin n_err++; $display("FAIL dual_still_req got %b exp 1", bus.req_valid); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL dual_req_done got %b exp 0", done); end
    next_cycle();
    bus.req_ready = 1'b0; bus.resp_valid = 1'b1; bus.resp_rdata = 64'h01234567_89ABCDEF;
    sample();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL dual_wait_done got %b exp 0", done); end
    next_cycle();
    bus.resp_valid = 1'b0;
    sample();
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL dual_done got %b exp 1", done); end
    n_vec++; if (mem_rd_data !== 64'h01234567_89ABCDEF) begin n_err++; $display("FAIL dual_rd_data got %h exp 0123456789abcdef", mem_rd_data); end
    clr_inputs();
    next_cycle();
  endtask

  // TIMEOUT=4: four silent WAIT cycles, then done+bus_err; late responses dropped.
  task automatic test_timeout();
    mem_rd_en = 1'b1; rd_mem_op = LD_OP_LW; rd_mem_addr = 64'h9000; bus.req_ready = 1'b1;
    sample();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL to_c0_stall got %b exp 1", stall); end
    next_cycle();
    mem_rd_en = 1'b0;
    sample();
    n_vec++; if (bus.req_valid !== 1'b1) begin n_err++; $display("FAIL to_req_valid got %b exp 1", bus.req_valid); end
    next_cycle();
    bus.req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL to_wait%0d_done got %b exp 0", i, done); end
      n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL to_wait%0d_bus_err got %b exp 0", i, bus_err); end
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL to_wait%0d_stall got %b exp 1", i, stall); end
      next_cycle();
    end
    bus.resp_valid = 1'b1; bus.resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    sample();
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL to_done got %b exp 1", done); end
    n_vec++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL to_bus_err got %b exp 1", bus_err); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL to_done_stall got %b exp 0", stall); end
    n_vec++; if (mem_rd_data !== 64'h0) begin n_err++; $display("FAIL to_rd_data got %h exp 0", mem_rd_data); end
    next_cycle();
    sample();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL to_late_done got %b exp 0", done); end
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL to_late_bus_err got %b exp 0", bus_err); end
    n_vec++; if (bus.req_valid !== 1'b0) begin n_err++; $display("FAIL to_late_req_valid got %b exp 0", bus.req_valid); end
    next_cycle();
    bus.resp_valid = 1'b0;
    sample();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL to_idle_done got %b exp 0", done); end
    n_vec++; if (mem_rd_data !== 64'h0) begin n_err++; $display("FAIL to_idle_rd_data got %h exp 0", mem_rd_data); end
    clr_inputs();
    next_cycle();
  endtask

  // Reset while in WAIT, response two cycles after reset was asserted.
  task automatic test_reset_in_wait();
    mem_rd_en = 1'b1; rd_mem_op = LD_OP_LW; rd_mem_addr = 64'hA000; bus.req_ready = 1'b1;
    sample();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rw_c0_stall got %b exp 1", stall); end
    next_cycle();
    mem_rd_en = 1'b0;
    sample();
    n_vec++; if (bus.req_valid !== 1'b1) begin n_err++; $display("FAIL rw_req_valid got %b exp 1", bus.req_valid); end
    next_cycle();
    bus.req_ready = 1'b0; rst = 1'b1;
    sample();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rw_wait_stall got %b exp 1", stall); end
    next_cycle();
    rst = 1'b0;
    sample();
    n_vec++; if (bus.req_valid !== 1'b0) begin n_err++; $display("FAIL rw_post_rst_valid got %b exp 0", bus.req_valid); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rw_post_rst_stall got %b exp 0", stall); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rw_post_rst_done got %b exp 0", done); end
    next_cycle();
    bus.resp_valid = 1'b1; bus.resp_rdata = 64'h7777_6666_5555_4444;
    sample();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rw_late_done got %b exp 0", done); end
    next_cycle();
    bus.resp_valid = 1'b0;
    sample();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rw_after_done got %b exp 0", done); end
    n_vec++; if (mem_rd_data !== 64'h0) begin n_err++; $display("FAIL rw_rd_data got %h exp 0", mem_rd_data); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rw_after_stall got %b exp 0", stall); end
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rw_after_bus_err got %b exp 0", bus_err); end
    n_vec++; if (bus.req_valid !== 1'b0) begin n_err++; $display("FAIL rw_after_req_valid got %b exp 0", bus.req_valid); end
    clr_inputs();
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_load_lw();
    test_store_sb();
    test_misalign();
    test_stall_ready();
    test_dual_start();
    test_timeout();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: TIMEOUT, 255, number of WAIT cycles without resp_valid before the access is abandoned with bus_err.
REQ-002 Clock and reset: single clock clk; reset rst is synchronous and active-high, sampled on the rising edge of clk.
REQ-003 Ports, in order:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_rd_en  in  1  load request from the decode stage
- mem_wr_en  in  1  store request from the decode stage
- rd_mem_op  in  7  load size, one-hot: LD=0000001, LW=0000010, LH=0000100, LB=0001000, LWU=0010000, LHU=0100000, LBU=1000000
- wr_mem_op  in  4  store size, one-hot: SD=0001, SW=0010, SH=0100, SB=1000
- rd_mem_addr  in  64  byte address, i.e. the ALU result after sign extension
- wr_mem_data  in  64  store data, i.e. rs2, right-aligned
- mem_rd_data  out  64  load data shifted so the addressed byte sits at bit 0; extension is done downstream
- stall  out  1  freezes PC and the pipeline while an access is outstanding
- done  out  1  one-cycle pulse when an access completes
- misalign  out  1  one-cycle pulse when an access is rejected for misalignment
- bus_err  out  1  one-cycle pulse when an access times out
- req_valid / req_ready  out / in  1 / 1  bus request handshake
- req_addr  out  64  8-byte-aligned address (addr[2:0]=0)
- req_we  out  1  1 for a store
- req_wdata  out  64  store data placed in its byte lanes
- req_wstrb  out  8  byte-lane write strobes
- resp_valid  in  1  read or write response
- resp_rdata  in  64  aligned doubleword read data

Function
REQ-004 FSM states are IDLE, REQ, WAIT, DONE; the state SHALL be registered.
REQ-005 Start condition: in IDLE, start = mem_rd_en|mem_wr_en.
- If both are high, the access is a load and the store is dropped.
- Starts in any other state are ignored.
REQ-006 On start in IDLE, a misaligned access SHALL stay in IDLE, pulse misalign for that same cycle, and never assert req_valid. Misalignment rules, with off = addr[2:0]:
- H/HU/SH: off[0]≠0
- W/WU/SW: off[1:0]≠0
- D/SD: off≠0
REQ-007 On an aligned start in IDLE, the block SHALL:
- latch addr, the op, we, the strobes and the shifted wdata;
- go to REQ next cycle.
REQ-008 REQ behaviour:
- req_valid=1, with req_* held stable until req_ready.
- On handshake (req_valid&req_ready), go to WAIT.
- resp_valid seen in REQ is ignored.
REQ-009 WAIT behaviour:
- On resp_valid, capture resp_rdata>>(off*8) into the mem_rd_data register and go to DONE.
- A wait counter counts the cycles spent in WAIT; on reaching TIMEOUT, go to DONE with bus_err pulsed and mem_rd_data=0.
REQ-010 In DONE, done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-011 stall = (IDLE&start&aligned) | REQ | WAIT.
- stall is low in DONE, so the pipeline advances while mem_rd_data is valid.
- mem_rd_data holds its value until the next capture.
REQ-012 Strobes: SB=8'h01<<off, SH=8'h03<<off, SW=8'h0F<<off, SD=8'hFF; wdata=wr_mem_data<<(off*8); loads drive wstrb=0.
REQ-013 Minimum latency with req_ready and resp_valid each asserted on the first possible cycle: start at cycle 0, done at cycle 3.
REQ-014 resp_valid received in IDLE or DONE SHALL be dropped without any effect.

Reset
REQ-015 After rst, the block SHALL be in:
- state=IDLE
- req_valid=0, req_we=0, req_addr=0, req_wdata=0, req_wstrb=0
- mem_rd_data=0, done=0, misalign=0, bus_err=0, stall=0
- wait counter=0
REQ-016 A reset during REQ or WAIT abandons the access; req_valid SHALL be low in the cycle after reset, and a late response is discarded per REQ-014.

Structure
REQ-017 A shared package SHALL hold:
- the 7-bit load and 4-bit store one-hot encodings, shared with the write-back control;
- the FSM state enum;
- the default TIMEOUT.
REQ-018 One combinational sub-module, lsu_align, SHALL generate the misalign flag, wstrb and shifted wdata from (op, off, data); the FSM and registers live in lsu.

Verification
REQ-019 LW at 0x1004, ready at once, resp one cycle later with rdata 0xDEADBEEF_12345678 -> mem_rd_data=0x00000000_DEADBEEF, done at cycle 3, stall high cycles 0–2.
REQ-020 SB at 0x2003 with data 0xAB -> req_addr=0x2000, wstrb=0x08, wdata[31:24]=0xAB, req_we=1.
REQ-021 LH at 0x3001 -> misalign pulse in cycle 0, req_valid never asserted, stall low.
REQ-022 req_ready held low for 5 cycles in REQ -> req_* stable throughout; one handshake only; stall high until DONE.
REQ-023 TIMEOUT=4 with no resp_valid -> bus_err and done pulse together, mem_rd_data=0; a later resp_valid is ignored.
REQ-024 rst asserted in WAIT, resp_valid arrives 2 cycles later -> outputs at reset values, no done pulse, mem_rd_data remains 0.
